mem_arbiter: RTL and testbench

Shares the single physical-memory port between the instruction-fetch requester (I-side cache) and the MEM-stage data requester (D-side cache) of the LC-3b pipeline. Holds one request in flight at a time, registers every physical-memory control/address/data output, and routes the response back to the granted requester only. Sits between the two L1 caches and physical memory, beneath the pipeline whose memory-op control is driven by the decode control ROM.

---
 rtl/lc3b_types.sv | 15 +
 rtl/arb_priority_sel.sv | 29 ++
 rtl/mem_arbiter.sv | 123 ++++++++++++
 tb/tb_mem_arbiter.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lc3b_types.sv
// Shared LC-3b types for the memory arbiter: FSM state and grant encodings.
package lc3b_types;

   typedef enum logic [1:0] {
      IDLE,
      BUSY_I,
      BUSY_D
   } arb_state_t;

   typedef enum logic {
      GNT_I,
      GNT_D
   } arb_gnt_t;

endpackage

// File: rtl/arb_priority_sel.sv
// Combinational winner pick between the I-side and D-side requesters.
// ARB_ROUND_ROBIN_EN selects alternating tie-break; otherwise D always wins ties.
module arb_priority_sel
   import lc3b_types::*;
(
   input  logic     i_req,
   input  logic     d_req,
`ifdef ARB_ROUND_ROBIN_EN
   input  arb_gnt_t last_grant,
`endif
   output arb_gnt_t gnt,
   output logic     valid
);

   always_comb begin
      valid = i_req | d_req;
      gnt   = GNT_D;
      if (i_req && !d_req) begin
         gnt = GNT_I;
      end
`ifdef ARB_ROUND_ROBIN_EN
      // On a tie, hand the port to whichever side did not have it last.
      else if (i_req && d_req && last_grant == GNT_D) begin
         gnt = GNT_I;
      end
`endif
   end

endmodule

// File: rtl/mem_arbiter.sv
// Single-outstanding arbiter sharing one physical-memory port between I and D caches.
// Optional ARB_ROUND_ROBIN_EN: round-robin tie-break instead of fixed D priority.
module mem_arbiter
   import lc3b_types::*;
#(
   parameter int ADDR_W = 16,
   parameter int LINE_W = 128
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              i_read,
   input  logic [ADDR_W-1:0] i_address,
   output logic [LINE_W-1:0] i_rdata,
   output logic              i_resp,
   input  logic              d_read,
   input  logic              d_write,
   input  logic [ADDR_W-1:0] d_address,
   input  logic [LINE_W-1:0] d_wdata,
   output logic [LINE_W-1:0] d_rdata,
   output logic              d_resp,
   output logic              pmem_read,
   output logic              pmem_write,
   output logic [ADDR_W-1:0] pmem_address,
   output logic [LINE_W-1:0] pmem_wdata,
   input  logic [LINE_W-1:0] pmem_rdata,
   input  logic              pmem_resp
);

   arb_state_t state, state_next;
   arb_gnt_t   gnt;
   logic       gnt_valid;
   logic       d_req;
   logic       launch;

   assign d_req = d_read | d_write;

`ifdef ARB_ROUND_ROBIN_EN
   arb_gnt_t last_grant;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         last_grant <= GNT_I;
      end else if (launch) begin
         last_grant <= gnt;
      end
   end
`endif

   arb_priority_sel u_sel (
      .i_req      (i_read),
      .d_req      (d_req),
`ifdef ARB_ROUND_ROBIN_EN
      .last_grant (last_grant),
`endif
      .gnt        (gnt),
      .valid      (gnt_valid)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Completion is forwarded in the same cycle memory signals it.
   always_comb begin
      state_next = state;
      launch     = 1'b0;
      i_resp     = 1'b0;
      d_resp     = 1'b0;
      case (state)
         IDLE: begin
            if (gnt_valid) begin
               launch     = 1'b1;
               state_next = (gnt == GNT_I) ? BUSY_I : BUSY_D;
            end
         end
         BUSY_I: begin
            if (pmem_resp) begin
               i_resp     = 1'b1;
               state_next = IDLE;
            end
         end
         BUSY_D: begin
            if (pmem_resp) begin
               d_resp     = 1'b1;
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   // A D-side request with both strobes high is a write; d_read is ignored.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pmem_read    <= 1'b0;
         pmem_write   <= 1'b0;
         pmem_address <= '0;
         pmem_wdata   <= '0;
      end else if (launch) begin
         if (gnt == GNT_I) begin
            pmem_read    <= 1'b1;
            pmem_write   <= 1'b0;
            pmem_address <= i_address;
         end else begin
            pmem_read    <= ~d_write;
            pmem_write   <= d_write;
            pmem_address <= d_address;
            pmem_wdata   <= d_wdata;
         end
      end else if (i_resp || d_resp) begin
         pmem_read  <= 1'b0;
         pmem_write <= 1'b0;
      end
   end

   assign i_rdata = pmem_rdata;
   assign d_rdata = pmem_rdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios plus random traffic against a transaction-level model.
module tb_mem_arbiter;

`ifdef ARB_ROUND_ROBIN_EN
   localparam bit RR = 1'b1;
`else
   localparam bit RR = 1'b0;
`endif

   logic         clk = 1'b0;
   logic         rst_n;
   logic         i_read;
   logic [15:0]  i_address;
   logic [127:0] i_rdata;
   logic         i_resp;
   logic         d_read;
   logic         d_write;
   logic [15:0]  d_address;
   logic [127:0] d_wdata;
   logic [127:0] d_rdata;
   logic         d_resp;
   logic         pmem_read;
   logic         pmem_write;
   logic [15:0]  pmem_address;
   logic [127:0] pmem_wdata;
   logic [127:0] pmem_rdata;
   logic         pmem_resp;

   mem_arbiter dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .i_read       (i_read),
      .i_address    (i_address),
      .i_rdata      (i_rdata),
      .i_resp       (i_resp),
      .d_read       (d_read),
      .d_write      (d_write),
      .d_address    (d_address),
      .d_wdata      (d_wdata),
      .d_rdata      (d_rdata),
      .d_resp       (d_resp),
      .pmem_read    (pmem_read),
      .pmem_write   (pmem_write),
      .pmem_address (pmem_address),
      .pmem_wdata   (pmem_wdata),
      .pmem_rdata   (pmem_rdata),
      .pmem_resp    (pmem_resp)
   );

   // clock / reset
   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog time limit reached");
      $fatal(1, "watchdog");
   end

   int checks = 0;
   int errors = 0;

   // transaction-level model: who owns the port (0 none, 1 I, 2 D) and what it asked for
   int           cur;
   bit           cur_wr;
   logic [15:0]  cur_addr;
   logic [127:0] cur_wdata;
   int           last_g;
   logic [1:0]   exp_q[$];

   // outputs sampled mid-cycle by step
   logic         smp_i_resp, smp_d_resp, smp_pread, smp_pwrite;
   logic [15:0]  smp_addr;
   logic [127:0] smp_wdata, smp_irdata, smp_drdata;

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
      end
   endtask

   // Called at a negedge with this cycle's inputs applied: compare, advance model, next negedge.
   task automatic step();
      int w;
      bit iq, dq;
      #1;
      smp_i_resp = i_resp;  smp_d_resp = d_resp;
      smp_pread  = pmem_read; smp_pwrite = pmem_write;
      smp_addr   = pmem_address; smp_wdata = pmem_wdata;
      smp_irdata = i_rdata; smp_drdata = d_rdata;
      chk("i_resp", 128'(i_resp), 128'(cur == 1 && pmem_resp));
      chk("d_resp", 128'(d_resp), 128'(cur == 2 && pmem_resp));
      chk("i_rdata", i_rdata, pmem_rdata);
      chk("d_rdata", d_rdata, pmem_rdata);
      chk("pmem_read", 128'(pmem_read), 128'(cur != 0 && !cur_wr));
      chk("pmem_write", 128'(pmem_write), 128'(cur != 0 && cur_wr));
      if (cur != 0) chk("pmem_address", 128'(pmem_address), 128'(cur_addr));
      if (cur != 0 && cur_wr) chk("pmem_wdata", pmem_wdata, cur_wdata);
      if (cur != 0) begin
         if (pmem_resp) cur = 0;
      end else begin
         iq = i_read;
         dq = d_read | d_write;
         w  = 0;
         if (iq && !dq) w = 1;
         else if (dq && !iq) w = 2;
         else if (iq && dq) w = RR ? ((last_g == 2) ? 1 : 2) : 2;
         if (w != 0) begin
            cur    = w;
            last_g = w;
            exp_q.push_back(2'(w));
            if (w == 1) begin
               cur_wr   = 1'b0;
               cur_addr = i_address;
            end else begin
               cur_wr    = d_write;
               cur_addr  = d_address;
               cur_wdata = d_wdata;
            end
         end
      end
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic drive_idle();
      i_read = 1'b0; i_address = '0;
      d_read = 1'b0; d_write = 1'b0; d_address = '0; d_wdata = '0;
      pmem_resp = 1'b0; pmem_rdata = '0;
   endtask

   // Assert reset at a negedge with pmem_resp high; everything must drop at once.
   task automatic do_reset();
      rst_n = 1'b0;
      pmem_resp = 1'b1;
      #1;
      chk("rst_pmem_read", 128'(pmem_read), 128'(0));
      chk("rst_pmem_write", 128'(pmem_write), 128'(0));
      chk("rst_pmem_address", 128'(pmem_address), 128'(0));
      chk("rst_pmem_wdata", pmem_wdata, 128'(0));
      chk("rst_i_resp", 128'(i_resp), 128'(0));
      chk("rst_d_resp", 128'(d_resp), 128'(0));
      @(posedge clk);
      @(negedge clk);
      rst_n  = 1'b1;
      cur    = 0;
      last_g = 1;
      exp_q.delete();
   endtask

   // driver tasks / scenarios
   initial begin
      logic [1:0] tie_exp[4];
      logic [1:0] tie_act[4];
      bit ip, dp;
      int k;

      drive_idle();
      rst_n = 1'b0;
      cur = 0; last_g = 1; cur_wr = 0; cur_addr = '0; cur_wdata = '0;
      @(negedge clk);
      do_reset();
      pmem_resp = 1'b0;

      // lone I read at 0x1230, memory answers in cycle 3
      i_read = 1'b1; i_address = 16'h1230;
      step();
      chk("lone_i_c0_read", 128'(smp_pread), 128'(0));
      step();
      chk("lone_i_c1_read", 128'(smp_pread), 128'(1));
      chk("lone_i_c1_addr", 128'(smp_addr), 128'(16'h1230));
      step();
      pmem_resp = 1'b1; pmem_rdata = {16{8'hA5}};
      step();
      chk("lone_i_c3_read", 128'(smp_pread), 128'(1));
      chk("lone_i_resp", 128'(smp_i_resp), 128'(1));
      chk("lone_i_rdata", smp_irdata, {16{8'hA5}});
      chk("lone_i_d_resp", 128'(smp_d_resp), 128'(0));
      drive_idle();
      step();
      chk("lone_i_after_read", 128'(smp_pread), 128'(0));
      chk("lone_i_after_resp", 128'(smp_i_resp), 128'(0));

      // D write at 0x4000
      d_write = 1'b1; d_address = 16'h4000; d_wdata = {32{4'h1}};
      step();
      step();
      chk("dwr_write", 128'(smp_pwrite), 128'(1));
      chk("dwr_addr", 128'(smp_addr), 128'(16'h4000));
      chk("dwr_wdata", smp_wdata, {32{4'h1}});
      step();
      pmem_resp = 1'b1;
      step();
      chk("dwr_resp", 128'(smp_d_resp), 128'(1));
      drive_idle();
      step();
      chk("dwr_resp_drop", 128'(smp_d_resp), 128'(0));
      chk("dwr_write_drop", 128'(smp_pwrite), 128'(0));

      // d_read and d_write together at 0x0010 is a write
      d_read = 1'b1; d_write = 1'b1; d_address = 16'h0010; d_wdata = {4{32'hCAFE_0010}};
      step();
      step();
      chk("both_write", 128'(smp_pwrite), 128'(1));
      chk("both_read", 128'(smp_pread), 128'(0));
      chk("both_addr", 128'(smp_addr), 128'(16'h0010));
      pmem_resp = 1'b1;
      step();
      drive_idle();
      step();

      // back-to-back I reads: resp at N, idle at N+1, new strobe at N+2
      i_read = 1'b1; i_address = 16'h2000;
      step();
      pmem_resp = 1'b1;
      step();
      chk("b2b_resp_n", 128'(smp_i_resp), 128'(1));
      pmem_resp = 1'b0; i_address = 16'h2040;
      step();
      chk("b2b_idle_n1", 128'(smp_pread), 128'(0));
      step();
      chk("b2b_read_n2", 128'(smp_pread), 128'(1));
      chk("b2b_addr_n2", 128'(smp_addr), 128'(16'h2040));
      pmem_resp = 1'b1;
      step();
      drive_idle();
      step();

      // tie with both requesting continuously
      do_reset();
      pmem_resp = 1'b0;
      tie_exp = RR ? '{2'd2, 2'd1, 2'd2, 2'd1} : '{2'd2, 2'd2, 2'd2, 2'd2};
      i_read = 1'b1; i_address = 16'h3000;
      d_read = 1'b1; d_address = 16'h5000;
      for (int t = 0; t < 4; t++) begin
         pmem_resp = 1'b0;
         step();
         pmem_resp = 1'b1;
         step();
         tie_act[t] = smp_d_resp ? 2'd2 : (smp_i_resp ? 2'd1 : 2'd0);
      end
      drive_idle();
      step();
      for (int t = 0; t < 4; t++) begin
         chk($sformatf("tie_dut_%0d", t), 128'(tie_act[t]), 128'(tie_exp[t]));
         chk($sformatf("tie_model_%0d", t), 128'(exp_q.size() > t ? exp_q[t] : 2'd0), 128'(tie_exp[t]));
      end

      // reset mid-BUSY_D with pmem_write high, then a stray pmem_resp
      d_write = 1'b1; d_address = 16'h4000; d_wdata = {32{4'h1}};
      step();
      step();
      chk("midrst_pre_write", 128'(smp_pwrite), 128'(1));
      do_reset();
      drive_idle();
      pmem_resp = 1'b1;
      step();
      chk("midrst_no_d_resp", 128'(smp_d_resp), 128'(0));
      chk("midrst_no_write", 128'(smp_pwrite), 128'(0));
      pmem_resp = 1'b0;
      step();

      // random traffic
      ip = 0; dp = 0;
      for (int n = 0; n < 3000; n++) begin
         if (!ip && $urandom_range(0, 2) == 0) begin
            ip = 1;
            i_address = 16'($urandom);
         end
         i_read = ip;
         if (!dp && $urandom_range(0, 2) == 0) begin
            dp = 1;
            d_address = 16'($urandom);
            d_wdata = {$urandom, $urandom, $urandom, $urandom};
            k = $urandom_range(0, 2);
            d_read  = (k != 1);
            d_write = (k != 0);
         end
         if (!dp) begin
            d_read = 1'b0; d_write = 1'b0;
         end
         pmem_rdata = {$urandom, $urandom, $urandom, $urandom};
         pmem_resp  = ($urandom_range(0, 2) == 0);
         step();
         if (smp_i_resp) ip = 0;
         if (smp_d_resp) dp = 0;
      end

      // final report
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
